param_measure_ctrl: RTL and testbench

Scheduler and configurator for the oscilloscope parameter-measurement datapath. It sequences fixed-length measurement windows, clears the min/max trackers at the start of each window and samples the frequency and amplitude results at its end. It runs a stability check on those samples, derives the trigger level (manual or auto-midpoint) and presents one result set per window to the display/UART consumer over a valid/ready handshake.

---
 rtl/param_measure_ctrl_if.sv | 22 ++
 rtl/param_measure_ctrl.sv | 178 +++++++++++++++++
 tb/tb_param_measure_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/param_measure_ctrl_if.sv
// Result handshake between the measurement scheduler and the display/UART consumer.
// The master side presents one result set per window; the slave side accepts it with res_ready.
interface param_measure_ctrl_if;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_freq;
    logic [7:0]  res_vpp;
    logic [7:0]  res_max;
    logic [7:0]  res_min;
    logic        res_unstable;
    logic        res_drop;

    modport master (
        output res_valid, res_freq, res_vpp, res_max, res_min, res_unstable, res_drop,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_freq, res_vpp, res_max, res_min, res_unstable, res_drop,
        output res_ready
    );
endinterface

// File: rtl/param_measure_ctrl.sv
// Measurement-window scheduler: clears min/max trackers, samples results with a stability check and publishes them.
// Define PMC_AUTO_TRIG_EN to include the auto-midpoint trigger level; otherwise trig_level follows trig_manual.
module param_measure_ctrl #(
    parameter int          CLK_FS    = 50_000_000,
    parameter int          UPDATE_MS = 200,
    parameter logic [7:0]  MIN_VPP   = 8'd10,
    parameter int          MAX_RETRY = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trig_mode,
    input  logic [7:0]                  trig_manual,
    input  logic [19:0]                 meas_freq,
    input  logic [7:0]                  meas_vpp,
    input  logic [7:0]                  meas_max,
    input  logic [7:0]                  meas_min,
    output logic [7:0]                  trig_level,
    output logic                        meas_clr,
    output logic                        sig_present,
    param_measure_ctrl_if.master        res_if
);
    localparam logic [31:0] PERIOD_CYC  = 32'(CLK_FS / 1000 * UPDATE_MS);
    localparam logic [7:0]  MAX_RETRY_L = 8'(MAX_RETRY);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT, S_SAMP1, S_SAMP2, S_UPDATE} state_t;

    typedef struct packed {
        logic [19:0] freq;
        logic [7:0]  vpp;
        logic [7:0]  vmax;
        logic [7:0]  vmin;
    } meas_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic        unstable_q, unstable_d;
    meas_t       a_q, a_d, b_q, b_d, res_q, res_d;
    logic        res_valid_q, res_valid_d;
    logic        res_unstable_q, res_unstable_d;
    logic        res_drop_q, res_drop_d;
    logic        meas_clr_q, meas_clr_d;
    logic        sig_present_q, sig_present_d;
    logic [7:0]  trig_q, trig_d;
    meas_t       cur;

    assign cur = '{freq: meas_freq, vpp: meas_vpp, vmax: meas_max, vmin: meas_min};

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        retry_d        = retry_q;
        unstable_d     = unstable_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        res_valid_d    = res_valid_q;
        res_unstable_d = res_unstable_q;
        res_drop_d     = 1'b0;
        meas_clr_d     = 1'b0;
        sig_present_d  = sig_present_q;

        if (res_valid_q && res_if.res_ready) begin
            res_valid_d = 1'b0;
        end

        // meas_clr is registered, so it is raised on the transition into CLEAR
        case (state_q)
            S_IDLE: begin
                state_d    = S_CLEAR;
                meas_clr_d = 1'b1;
            end
            S_CLEAR: begin
                cnt_d      = PERIOD_CYC - 32'd1;
                retry_d    = 8'd0;
                unstable_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_SAMP1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_SAMP1: begin
                a_d     = cur;
                state_d = S_SAMP2;
            end
            S_SAMP2: begin
                b_d = cur;
                if (cur == a_q) begin
                    state_d = S_UPDATE;
                end else if (retry_q < MAX_RETRY_L) begin
                    retry_d = retry_q + 8'd1;
                    state_d = S_SAMP1;
                end else begin
                    unstable_d = 1'b1;
                    state_d    = S_UPDATE;
                end
            end
            S_UPDATE: begin
                res_d          = b_q;
                res_unstable_d = unstable_q;
                res_valid_d    = 1'b1;
                res_drop_d     = res_valid_q && !res_if.res_ready;
                if (b_q.vpp < MIN_VPP) begin
                    res_d.freq    = 20'd0;
                    sig_present_d = 1'b0;
                end else begin
                    sig_present_d = 1'b1;
                end
                state_d    = S_CLEAR;
                meas_clr_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef PMC_AUTO_TRIG_EN
        trig_d = trig_q;
        if (!trig_mode) begin
            trig_d = trig_manual;
        end else if (state_q == S_UPDATE && b_q.vpp >= MIN_VPP) begin
            trig_d = 8'(({1'b0, b_q.vmax} + {1'b0, b_q.vmin}) >> 1);
        end
`else
        trig_d = trig_manual;
`endif
    end

`ifndef PMC_AUTO_TRIG_EN
    logic unused_trig_mode;
    assign unused_trig_mode = trig_mode;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            retry_q        <= '0;
            unstable_q     <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            res_q          <= '0;
            res_valid_q    <= 1'b0;
            res_unstable_q <= 1'b0;
            res_drop_q     <= 1'b0;
            meas_clr_q     <= 1'b0;
            sig_present_q  <= 1'b0;
            trig_q         <= 8'd128;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            unstable_q     <= unstable_d;
            a_q            <= a_d;
            b_q            <= b_d;
            res_q          <= res_d;
            res_valid_q    <= res_valid_d;
            res_unstable_q <= res_unstable_d;
            res_drop_q     <= res_drop_d;
            meas_clr_q     <= meas_clr_d;
            sig_present_q  <= sig_present_d;
            trig_q         <= trig_d;
        end
    end

    assign trig_level          = trig_q;
    assign meas_clr            = meas_clr_q;
    assign sig_present         = sig_present_q;
    assign res_if.res_valid    = res_valid_q;
    assign res_if.res_freq     = res_q.freq;
    assign res_if.res_vpp      = res_q.vpp;
    assign res_if.res_max      = res_q.vmax;
    assign res_if.res_min      = res_q.vmin;
    assign res_if.res_unstable = res_unstable_q;
    assign res_if.res_drop     = res_drop_q;
endmodule

// File: tb/tb_param_measure_ctrl.sv
// Directed bench for param_measure_ctrl with a 10-cycle window (CLK_FS=1000, UPDATE_MS=10).
// Cycle Cn is the n-th cycle after reset release; outputs are sampled on the falling edge.
module tb_param_measure_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig_mode = 1'b1;
    logic [7:0]  trig_manual = 8'd128;
    logic [19:0] meas_freq = 20'd0;
    logic [7:0]  meas_vpp = 8'd0;
    logic [7:0]  meas_max = 8'd0;
    logic [7:0]  meas_min = 8'd0;
    logic [7:0]  trig_level;
    logic        meas_clr;
    logic        sig_present;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic toggle_en = 1'b0;

    param_measure_ctrl_if res_if ();

    param_measure_ctrl #(
        .CLK_FS    (1000),
        .UPDATE_MS (10),
        .MIN_VPP   (8'd10),
        .MAX_RETRY (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_mode   (trig_mode),
        .trig_manual (trig_manual),
        .meas_freq   (meas_freq),
        .meas_vpp    (meas_vpp),
        .meas_max    (meas_max),
        .meas_min    (meas_min),
        .trig_level  (trig_level),
        .meas_clr    (meas_clr),
        .sig_present (sig_present),
        .res_if      (res_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @C%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
            if (toggle_en) meas_freq = meas_freq ^ 20'h1;
        end
    endtask

    task automatic set_in(input logic [19:0] f, input logic [7:0] v, input logic [7:0] mx, input logic [7:0] mn);
        meas_freq = f;
        meas_vpp  = v;
        meas_max  = mx;
        meas_min  = mn;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        res_if.res_ready = 1'b0;
        set_in(20'd1234, 8'd160, 8'd200, 8'd40);

        // reset, auto trigger, then backpressure across two windows
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", res_if.res_valid, 0);
        chk("rst_trig", trig_level, 128);
        do_reset();
        chk("c0_clr", meas_clr, 0);
        chk("c0_trig", trig_level, 128);
        goto(1);
        chk("c1_clr", meas_clr, 1);
        goto(2);
        chk("c2_clr", meas_clr, 0);
        goto(14);
        chk("c14_valid", res_if.res_valid, 0);
        chk("c14_trig", trig_level, 128);
        goto(15);
        chk("c15_valid", res_if.res_valid, 1);
        chk("c15_freq", res_if.res_freq, 1234);
        chk("c15_vpp", res_if.res_vpp, 160);
        chk("c15_max", res_if.res_max, 200);
        chk("c15_min", res_if.res_min, 40);
        chk("c15_sig", sig_present, 1);
        chk("c15_unst", res_if.res_unstable, 0);
        chk("c15_clr", meas_clr, 1);
`ifdef PMC_AUTO_TRIG_EN
        chk("c15_trig", trig_level, 120);
`else
        chk("c15_trig", trig_level, 128);
`endif
        set_in(20'd555, 8'd100, 8'd150, 8'd50);
        goto(28);
        chk("bp_hold_freq", res_if.res_freq, 1234);
        chk("bp_hold_valid", res_if.res_valid, 1);
        chk("bp_nodrop", res_if.res_drop, 0);
        goto(29);
        chk("bp_drop", res_if.res_drop, 1);
        chk("bp_valid", res_if.res_valid, 1);
        chk("bp_freq", res_if.res_freq, 555);
        chk("bp_vpp", res_if.res_vpp, 100);
`ifdef PMC_AUTO_TRIG_EN
        chk("bp_trig", trig_level, 100);
`else
        chk("bp_trig", trig_level, 128);
`endif
        goto(30);
        chk("bp_drop_end", res_if.res_drop, 0);
        chk("bp_valid_30", res_if.res_valid, 1);
        res_if.res_ready = 1'b1;
        goto(31);
        chk("bp_accept", res_if.res_valid, 0);
        res_if.res_ready = 1'b0;

        // no signal: frequency forced to zero, auto level held
        set_in(20'd1234, 8'd5, 8'd130, 8'd125);
        do_reset();
        goto(15);
        chk("ns_valid", res_if.res_valid, 1);
        chk("ns_freq", res_if.res_freq, 0);
        chk("ns_vpp", res_if.res_vpp, 5);
        chk("ns_sig", sig_present, 0);
        chk("ns_trig", trig_level, 128);

        // unstable inputs: three retries push res_valid out by 6 cycles
        set_in(20'd1234, 8'd160, 8'd200, 8'd40);
        do_reset();
        toggle_en = 1'b1;
        goto(20);
        chk("un_valid_20", res_if.res_valid, 0);
        goto(21);
        toggle_en = 1'b0;
        chk("un_valid_21", res_if.res_valid, 1);
        chk("un_flag", res_if.res_unstable, 1);
        chk("un_freq", res_if.res_freq, 1235);

        // reset in the middle of WAIT with a result pending
        set_in(20'd1234, 8'd160, 8'd200, 8'd40);
        do_reset();
        goto(15);
        chk("mr_valid_pre", res_if.res_valid, 1);
        goto(20);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_valid", res_if.res_valid, 0);
        chk("mr_freq", res_if.res_freq, 0);
        chk("mr_sig", sig_present, 0);
        chk("mr_trig", trig_level, 128);
        chk("mr_clr", meas_clr, 0);
        chk("mr_drop", res_if.res_drop, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        chk("mr_c0_clr", meas_clr, 0);
        goto(1);
        chk("mr_c1_clr", meas_clr, 1);
        goto(14);
        chk("mr_c14_valid", res_if.res_valid, 0);
        goto(15);
        chk("mr_c15_valid", res_if.res_valid, 1);

        // switch to manual mid-stream
        trig_mode   = 1'b0;
        trig_manual = 8'd77;
        goto(16);
        chk("man_trig", trig_level, 77);
        trig_manual = 8'd33;
        goto(17);
        chk("man_trig2", trig_level, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
